id_regstage: RTL
================

Name: id_regstage

Overview:
- Parametrised decode-stage register file plus ID/EX pipeline register. Replaces the stall/flush-only decode register with a valid/ready handshake.
- Sits between the decode logic (control unit and immediate generator, which stay external and feed `in_*`) and EX.
- Register file writes occur on the posedge only. Same-cycle writeback is bypassed into the read. Operands held in a stalled ID/EX slot are refreshed by later writebacks, so a stall never leaves stale data.

Parameters:
- XLEN, 32, datapath width.
- NUM_REGS, 32, architectural register count (power of 2). AW = $clog2(NUM_REGS).
- CTRL_W, 16, width of the packed control bundle from the control unit.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero (writes dropped, reads return 0).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the ID/EX slot.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept.
- in_rs1, in_rs2, in_rd  in  AW each  register addresses.
- in_imm  in  XLEN  immediate.
- in_ctrl  in  CTRL_W  control bundle.
- in_pc, in_pc_plus_4  in  XLEN each.
- wb_en  in  1  writeback enable.
- wb_rd  in  AW  writeback address.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  ID/EX slot valid.
- out_ready  in  1  EX accepts.
- out_rs1_data, out_rs2_data  out  XLEN each  operands.
- out_rs1, out_rs2, out_rd  out  AW each  addresses (for hazard/forward unit).
- out_imm  out  XLEN.
- out_ctrl  out  CTRL_W.
- out_pc, out_pc_plus_4  out  XLEN each.

Behaviour:
- Reset (asynchronous): all registers clear to 0; out_valid = 0; every out_* = 0.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Load: on a posedge with in_valid && in_ready && !flush, capture all in_* fields, set out_valid = 1. Latency is 1 cycle.
- Drain: out_valid && out_ready && !(in_valid && in_ready) sets out_valid = 0. Data fields hold their values.
- Flush has top priority: out_valid = 0 next cycle and any concurrent load is dropped. Data fields hold; only out_valid is cleared.
- Register file write: at a posedge with wb_en = 1, reg[wb_rd] = wb_data. When ZERO_REG = 1 and wb_rd = 0, the write is dropped.
- Read at load (write-first bypass): if wb_en && wb_rd == in_rsN && !(ZERO_REG && in_rsN == 0), capture wb_data; otherwise capture reg[in_rsN].
- Hold refresh: while out_valid = 1 and no load occurs, wb_en && wb_rd == out_rsN (nonzero when ZERO_REG) sets out_rsN_data = wb_data.
  - rs1 and rs2 are refreshed independently.
  - Both are refreshed when out_rs1 == out_rs2.
- Refresh is also applied while out_valid = 0. This is harmless and keeps the logic simple.
- Simultaneous drain and load: the new instruction wins, with no bubble, for full throughput.
- Reset mid-stall clears both the slot and the register file.

Optional Feature:
- Macro: ID_PERF_CNT_EN.
- When defined, adds ports:
  - perf_stall_cnt  out  32  counts cycles with out_valid && !out_ready.
  - perf_flush_cnt  out  32  counts flush cycles where out_valid = 1 or a load was dropped.
  - Both counters wrap modulo 2^32 and reset to 0.
- When undefined: no ports, no counter logic, and behaviour is otherwise identical.

Decomposition:
- Package id_pkg holds:
  - XLEN_DEF and NUM_REGS_DEF.
  - typedef reg_addr_t.
  - CTRL_W and the bit offsets of the control bundle fields (regwrite, result_src, memwrite, jump, branch, alu_control, branch_control, alu_src).
- Sub-module id_regfile: 2 async read ports, 1 posedge write port, async reset clears, ZERO_REG handling. The bypass and refresh logic stay in the parent.

Test Plan:
- Reset, then load in_rs1 = 3, in_rs2 = 0 → out_valid = 1 next cycle, out_rs1_data = 0, out_rs2_data = 0; x0 reads 0.
- wb_en = 1, wb_rd = 5, wb_data = 0xDEADBEEF in the same cycle as a load with in_rs1 = 5 → out_rs1_data = 0xDEADBEEF (bypass).
- Hold out_ready = 0 with out_rs2 = 7, then write reg7 = 0x1234 → out_rs2_data becomes 0x1234 while stalled and in_ready = 0. A flush in the same cycle as an in_valid load → out_valid = 0; the load is not seen afterwards.
- wb_en = 1, wb_rd = 0, wb_data = 0xFFFFFFFF with ZERO_REG = 1 → subsequent reads of x0 return 0.
- Back-to-back loads with out_ready = 1 every cycle → one instruction per cycle, no bubble. With ID_PERF_CNT_EN, 3 stall cycles give perf_stall_cnt = 3.

Source files
------------

// File: rtl/id_regstage_pkg.sv
// Shared defaults and control-bundle field layout for the decode register stage.
// The bit offsets describe how the external control unit packs in_ctrl.
package id_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

   typedef logic [AW_DEF-1:0] reg_addr_t;

   localparam int CTRL_W = 16;

   // Control bundle layout (LSB first); bits 14..15 are spare.
   localparam int CTRL_REGWRITE_BIT   = 0;
   localparam int CTRL_RESULT_SRC_LSB = 1;
   localparam int CTRL_RESULT_SRC_W   = 2;
   localparam int CTRL_MEMWRITE_BIT   = 3;
   localparam int CTRL_JUMP_BIT       = 4;
   localparam int CTRL_BRANCH_BIT     = 5;
   localparam int CTRL_ALU_CTRL_LSB   = 6;
   localparam int CTRL_ALU_CTRL_W     = 4;
   localparam int CTRL_BR_CTRL_LSB    = 10;
   localparam int CTRL_BR_CTRL_W      = 3;
   localparam int CTRL_ALU_SRC_BIT    = 13;

   typedef enum logic [1:0] {
      RES_ALU  = 2'd0,
      RES_MEM  = 2'd1,
      RES_PC4  = 2'd2,
      RES_IMM  = 2'd3
   } result_src_e;

   function automatic logic ctrl_regwrite(input logic [CTRL_W-1:0] i_ctrl);
      return i_ctrl[CTRL_REGWRITE_BIT];
   endfunction

   function automatic result_src_e ctrl_result_src(input logic [CTRL_W-1:0] i_ctrl);
      return result_src_e'(i_ctrl[CTRL_RESULT_SRC_LSB +: CTRL_RESULT_SRC_W]);
   endfunction

endpackage

// File: rtl/id_regstage_if.sv
// Handshake and datapath bundle between decode, writeback and EX for id_regstage.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface id_regstage_if #(
   parameter int XLEN   = id_pkg::XLEN_DEF,
   parameter int AW     = id_pkg::AW_DEF,
   parameter int CTRL_W = id_pkg::CTRL_W
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [AW-1:0]     in_rs1;
   logic [AW-1:0]     in_rs2;
   logic [AW-1:0]     in_rd;
   logic [XLEN-1:0]   in_imm;
   logic [CTRL_W-1:0] in_ctrl;
   logic [XLEN-1:0]   in_pc;
   logic [XLEN-1:0]   in_pc_plus_4;

   logic              wb_en;
   logic [AW-1:0]     wb_rd;
   logic [XLEN-1:0]   wb_data;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_rs1_data;
   logic [XLEN-1:0]   out_rs2_data;
   logic [AW-1:0]     out_rs1;
   logic [AW-1:0]     out_rs2;
   logic [AW-1:0]     out_rd;
   logic [XLEN-1:0]   out_imm;
   logic [CTRL_W-1:0] out_ctrl;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_pc_plus_4;

   modport master (
      output flush, in_valid, in_rs1, in_rs2, in_rd, in_imm, in_ctrl, in_pc, in_pc_plus_4,
      output wb_en, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd,
      input  out_imm, out_ctrl, out_pc, out_pc_plus_4
   );

   modport slave (
      input  flush, in_valid, in_rs1, in_rs2, in_rd, in_imm, in_ctrl, in_pc, in_pc_plus_4,
      input  wb_en, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd,
      output out_imm, out_ctrl, out_pc, out_pc_plus_4
   );

endinterface

// File: rtl/id_regstage_regfile.sv
// Architectural register file: two async read ports, one posedge write port,
// async clear, optional hardwired-zero register 0.
module id_regfile
   import id_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr1,
   output logic [XLEN-1:0] o_rdata1,
   input  logic [AW-1:0]   i_raddr2,
   output logic [XLEN-1:0] o_rdata2
);

   logic [XLEN-1:0] r_regs [NUM_REGS];
   logic            w_we_live;

   assign w_we_live = i_we && !((ZERO_REG != 0) && (i_waddr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_we_live) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = ((ZERO_REG != 0) && (i_raddr1 == '0)) ? '0 : r_regs[i_raddr1];
   assign o_rdata2 = ((ZERO_REG != 0) && (i_raddr2 == '0)) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/id_regstage.sv
// Decode-stage register file plus ID/EX slot with valid/ready handshake.
// Optional perf counters are built when ID_PERF_CNT_EN is defined.
module id_regstage #(
   parameter int XLEN     = id_pkg::XLEN_DEF,
   parameter int NUM_REGS = id_pkg::NUM_REGS_DEF,
   parameter int CTRL_W   = id_pkg::CTRL_W,
   parameter int ZERO_REG = 1
) (
   input  logic        clk,
   input  logic        reset,
   id_regstage_if.slave bus
`ifdef ID_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);
   import id_pkg::*;

   localparam int AW = $clog2(NUM_REGS);

   logic              r_out_valid;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [AW-1:0]     r_rs1;
   logic [AW-1:0]     r_rs2;
   logic [AW-1:0]     r_rd;
   logic [XLEN-1:0]   r_imm;
   logic [CTRL_W-1:0] r_ctrl;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_pc_plus_4;

   logic              w_in_ready;
   logic              w_load;
   logic [XLEN-1:0]   w_rf_rdata1;
   logic [XLEN-1:0]   w_rf_rdata2;
   logic              w_byp1;
   logic              w_byp2;
   logic [XLEN-1:0]   w_rd_data1;
   logic [XLEN-1:0]   w_rd_data2;
   logic              w_ref1;
   logic              w_ref2;

   id_regfile #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_regfile (
      .clk      (clk),
      .rst      (reset),
      .i_we     (bus.wb_en),
      .i_waddr  (bus.wb_rd),
      .i_wdata  (bus.wb_data),
      .i_raddr1 (bus.in_rs1),
      .o_rdata1 (w_rf_rdata1),
      .i_raddr2 (bus.in_rs2),
      .o_rdata2 (w_rf_rdata2)
   );

   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_load     = bus.in_valid && w_in_ready && !bus.flush;

   // Write-first: a writeback landing this edge is visible to the capturing read.
   assign w_byp1 = bus.wb_en && (bus.wb_rd == bus.in_rs1) && !((ZERO_REG != 0) && (bus.in_rs1 == '0));
   assign w_byp2 = bus.wb_en && (bus.wb_rd == bus.in_rs2) && !((ZERO_REG != 0) && (bus.in_rs2 == '0));
   assign w_rd_data1 = w_byp1 ? bus.wb_data : w_rf_rdata1;
   assign w_rd_data2 = w_byp2 ? bus.wb_data : w_rf_rdata2;

   // Held operands track later writebacks so a long stall never goes stale.
   assign w_ref1 = bus.wb_en && (bus.wb_rd == r_rs1) && !((ZERO_REG != 0) && (r_rs1 == '0));
   assign w_ref2 = bus.wb_en && (bus.wb_rd == r_rs2) && !((ZERO_REG != 0) && (r_rs2 == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_imm       <= '0;
         r_ctrl      <= '0;
         r_pc        <= '0;
         r_pc_plus_4 <= '0;
      end else begin
         if (bus.flush) begin
            r_out_valid <= 1'b0;
         end else if (w_load) begin
            r_out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_load) begin
            r_rs1_data  <= w_rd_data1;
            r_rs2_data  <= w_rd_data2;
            r_rs1       <= bus.in_rs1;
            r_rs2       <= bus.in_rs2;
            r_rd        <= bus.in_rd;
            r_imm       <= bus.in_imm;
            r_ctrl      <= bus.in_ctrl;
            r_pc        <= bus.in_pc;
            r_pc_plus_4 <= bus.in_pc_plus_4;
         end else begin
            if (w_ref1) r_rs1_data <= bus.wb_data;
            if (w_ref2) r_rs2_data <= bus.wb_data;
         end
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_rs1_data  = r_rs1_data;
   assign bus.out_rs2_data  = r_rs2_data;
   assign bus.out_rs1       = r_rs1;
   assign bus.out_rs2       = r_rs2;
   assign bus.out_rd        = r_rd;
   assign bus.out_imm       = r_imm;
   assign bus.out_ctrl      = r_ctrl;
   assign bus.out_pc        = r_pc;
   assign bus.out_pc_plus_4 = r_pc_plus_4;

`ifdef ID_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic        w_flush_hit;

   // A flush counts when it kills a live slot or swallows an otherwise-accepted load.
   assign w_flush_hit = bus.flush && (r_out_valid || (bus.in_valid && w_in_ready));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (r_out_valid && !bus.out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush_hit)                   r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
   assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
